// File: rtl/count_mon_pkg.sv
// Shared types and widths for the ripple-counter monitor.
package count_mon_pkg;

    localparam int unsigned COUNT_W = 4;
    localparam int unsigned WRAP_W  = 8;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        LOCKED = 2'd1,
        SETTLE = 2'd2
    } state_e;

endpackage

// File: rtl/count_sync.sv
// Plain flop-chain synchronizer; stage 0 samples the asynchronous input.
module count_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/count_monitor.sv
// Synchronizes and debounces a rippling counter, tracks threshold match and wraps.
// Wrap pulse/counter logic exists only when COUNT_MON_WRAP_CNT_EN is defined.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    input  logic [COUNT_W-1:0] threshold,
    input  logic               clr,
    output logic [COUNT_W-1:0] value,
    output logic               valid,
    output logic               match,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_cnt
);

    localparam int unsigned STAB_W = 3;

    logic [COUNT_W-1:0] sync_s;
    logic [COUNT_W-1:0] p_q, p_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    state_e             state_q, state_d;
    logic [COUNT_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;
    logic               match_q, match_d;
    logic               stable_c;
    logic               upd_c;

    count_sync #(
        .WIDTH  (COUNT_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (count_in),
        .q_out (sync_s)
    );

    // Stability tracking: a sample counts as stable only while it equals its predecessor
    always_comb begin
        p_d    = sync_s;
        stab_d = stab_q;
        if (sync_s != p_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_W'(STABLE_CYCLES)) begin
            stab_d = stab_q + 1'b1;
        end
        stable_c = (stab_q == STAB_W'(STABLE_CYCLES)) && (sync_s == p_q);
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        valid_d = valid_q;
        match_d = clr ? 1'b0 : match_q;
        upd_c   = 1'b0;
        case (state_q)
            INIT: begin
                if (stable_c) begin
                    upd_c   = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (sync_s != value_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Settling back onto the held value is a rejected glitch
                if (stable_c) begin
                    state_d = LOCKED;
                    upd_c   = (sync_s != value_q);
                end
            end
            default: state_d = INIT;
        endcase
        if (upd_c) begin
            value_d = sync_s;
            valid_d = 1'b1;
            if (sync_s == threshold) begin
                match_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q     <= '0;
            stab_q  <= '0;
            state_q <= INIT;
            value_q <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            stab_q  <= stab_d;
            state_q <= state_d;
            value_q <= value_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign match = match_q;

`ifdef COUNT_MON_WRAP_CNT_EN
    logic              wrap_c;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // A wrap is any decrease of an already valid value
    always_comb begin
        wrap_c       = upd_c && valid_q && (sync_s < value_q);
        wrap_pulse_d = wrap_c;
        wrap_cnt_d   = wrap_cnt_q;
        if (wrap_c && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
`else
    assign wrap_pulse = 1'b0;
    assign wrap_cnt   = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: vector table plus hand sequences for reset and wrap cases.
module tb_count_monitor;

`ifdef COUNT_MON_WRAP_CNT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic [3:0] threshold;
    logic       clr;
    logic [3:0] value;
    logic       valid;
    logic       match;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    count_monitor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .threshold  (threshold),
        .clr        (clr),
        .value      (value),
        .valid      (valid),
        .match      (match),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cin;
        logic [3:0] thr;
        logic       clr;
        int         edges;
        logic [3:0] e_val;
        logic       e_vld;
        logic       e_mat;
        logic       e_wp;
        logic [7:0] e_wc;
    } vec_t;

    vec_t tv [12];

    function automatic vec_t mk(input logic [3:0] cin, input logic [3:0] thr, input logic c,
                                input int edges, input logic [3:0] v, input logic vld,
                                input logic m, input logic wp, input logic [7:0] wc);
        vec_t r;
        r.cin = cin; r.thr = thr; r.clr = c; r.edges = edges;
        r.e_val = v; r.e_vld = vld; r.e_mat = m; r.e_wp = wp; r.e_wc = wc;
        return r;
    endfunction

    // Expected wrap count for n detected wraps in this build
    function automatic logic [7:0] wexp(input int n);
        if (!WEN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] v, input logic vld,
                           input logic m, input logic wp, input logic [7:0] wc);
        chk({tag, ".value"},      32'(value),      32'(v));
        chk({tag, ".valid"},      32'(valid),      32'(vld));
        chk({tag, ".match"},      32'(match),      32'(m));
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
        chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(wc));
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Step 3->4, glitch 4->7->4, match/clr, clr coincident with re-accept (7->6 is a wrap)
        tv[0]  = mk(4'd4, 4'd9, 1'b0, 5, 4'd3, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[1]  = mk(4'd4, 4'd9, 1'b0, 1, 4'd4, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[2]  = mk(4'd7, 4'd7, 1'b0, 1, 4'd4, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[3]  = mk(4'd4, 4'd7, 1'b0, 8, 4'd4, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[4]  = mk(4'd6, 4'd6, 1'b0, 5, 4'd4, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[5]  = mk(4'd6, 4'd6, 1'b0, 1, 4'd6, 1'b1, 1'b1, 1'b0, wexp(0));
        tv[6]  = mk(4'd7, 4'd6, 1'b0, 6, 4'd7, 1'b1, 1'b1, 1'b0, wexp(0));
        tv[7]  = mk(4'd7, 4'd6, 1'b1, 1, 4'd7, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[8]  = mk(4'd7, 4'd6, 1'b0, 1, 4'd7, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[9]  = mk(4'd6, 4'd6, 1'b0, 5, 4'd7, 1'b1, 1'b0, 1'b0, wexp(0));
        tv[10] = mk(4'd6, 4'd6, 1'b1, 1, 4'd6, 1'b1, 1'b1, WEN,  wexp(1));
        tv[11] = mk(4'd6, 4'd6, 1'b0, 1, 4'd6, 1'b1, 1'b1, 1'b0, wexp(1));

        reset     = 1'b0;
        count_in  = 4'd3;
        threshold = 4'd9;
        clr       = 1'b0;
        #1 reset = 1'b1;
        #1 chk_all("reset_async", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Release just before edge 0; value must appear on edge 5, not edge 4
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_edges(5);
        chk_all("init_edge4", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        wait_edges(1);
        chk_all("init_edge5", 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 12; i++) begin
            count_in  = tv[i].cin;
            threshold = tv[i].thr;
            clr       = tv[i].clr;
            wait_edges(tv[i].edges);
            chk_all($sformatf("vec%0d", i), tv[i].e_val, tv[i].e_vld, tv[i].e_mat,
                    tv[i].e_wp, tv[i].e_wc);
        end
        clr = 1'b0;

        // Reset while settling on a new value
        count_in = 4'd9;
        wait_edges(3);
        chk_all("pre_settle_reset", 4'd6, 1'b1, 1'b1, 1'b0, wexp(1));
        reset = 1'b1;
        #1 chk_all("settle_reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_edges(5);
        chk_all("reacq_edge4", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        wait_edges(1);
        chk_all("reacq_edge5", 4'd9, 1'b1, 1'b0, 1'b0, 8'd0);

        // 15 -> 0 wrap with exact pulse timing
        count_in = 4'd15;
        wait_edges(6);
        chk_all("at_15", 4'd15, 1'b1, 1'b0, 1'b0, wexp(0));
        count_in = 4'd0;
        wait_edges(5);
        chk_all("wrap_pre", 4'd15, 1'b1, 1'b0, 1'b0, wexp(0));
        wait_edges(1);
        chk_all("wrap_edge", 4'd0, 1'b1, 1'b0, WEN, wexp(1));
        wait_edges(1);
        chk_all("wrap_after", 4'd0, 1'b1, 1'b0, 1'b0, wexp(1));

        // 300 further 1->0 wraps, checking just below saturation and at it
        for (int i = 0; i < 300; i++) begin
            count_in = 4'd1;
            wait_edges(6);
            count_in = 4'd0;
            wait_edges(6);
            if (i == 252) chk("wrap_cnt_254", 32'(wrap_cnt), 32'(wexp(254)));
        end
        chk("wrap_cnt_sat", 32'(wrap_cnt), 32'(wexp(301)));

        // 5 -> 3 decrease is a wrap; count stays saturated
        count_in = 4'd5;
        wait_edges(6);
        chk_all("at_5", 4'd5, 1'b1, 1'b0, 1'b0, wexp(301));
        count_in = 4'd3;
        wait_edges(6);
        chk_all("dec_5_3", 4'd3, 1'b1, 1'b0, WEN, wexp(302));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on count_in (legal range 2..4).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 2, meaning the number of consecutive equal synchronized samples required to accept a value (legal range 1..7).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its posedge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port count_in, input, 4, the raw ripple-counter output, asynchronous to clk and possibly glitching while rippling.
REQ-006 The block SHALL have port threshold, input, 4, the compare value, synchronous to clk.
REQ-007 The block SHALL have port clr, input, 1, a pulse that clears match.
REQ-008 The block SHALL have port value, output, 4, the last accepted count.
REQ-009 The block SHALL have port valid, output, 1, high once any value has been accepted.
REQ-010 The block SHALL have port match, output, 1, a sticky flag set when an accepted value equals threshold.
REQ-011 The block SHALL have port wrap_pulse, output, 1, a one-cycle strobe on a detected wrap-around.
REQ-012 The block SHALL have port wrap_cnt, output, 8, the number of wraps detected, saturating.

Function
REQ-013 count_in SHALL pass through SYNC_STAGES flops to give sample s; no logic SHALL sit between the stages.
REQ-014 The block SHALL hold the previous sample p and a stability counter that resets to 0 when s != p and increments (saturating at STABLE_CYCLES) when s == p.
REQ-015 The FSM SHALL have exactly the states INIT, LOCKED and SETTLE.
REQ-016 In INIT (valid=0), when the stability counter reaches STABLE_CYCLES the block SHALL load value <= s, set valid and go to LOCKED; no wrap detection SHALL occur on this first accept.
REQ-017 In LOCKED, if s != value the FSM SHALL go to SETTLE; otherwise it SHALL stay in LOCKED.
REQ-018 In SETTLE, when the stability counter reaches STABLE_CYCLES the block SHALL accept s; if s == value it SHALL return to LOCKED with no update (a glitch was rejected).
REQ-019 The latency SHALL be that, with count_in stable from edge k, value reflects it by edge k+SYNC_STAGES+STABLE_CYCLES+1.
REQ-020 Wrap SHALL be detected on accept when valid=1 and new value < old value: wrap_pulse high for exactly that one cycle, and wrap_cnt += 1, saturating at 255.
REQ-021 On accept with new value == threshold, match SHALL be set on the same edge; a change of threshold alone SHALL NOT set match.
REQ-022 clr SHALL clear match on the next edge; when clr and a set event occur in the same cycle, set SHALL win.
REQ-023 Wrap SHALL be defined by a value decrease only: a skipped code (e.g. 14->1) counts as one wrap, and 5->3 also counts as a wrap.

Reset
REQ-024 While reset is high, all outputs SHALL read 0 asynchronously: value=0, valid=0, match=0, wrap_pulse=0, wrap_cnt=0.
REQ-025 Reset SHALL also clear the sync flops, p and the stability counter, and set FSM=INIT.
REQ-026 A reset asserted mid-SETTLE SHALL discard the pending sample; after release the block SHALL behave as from power-up.

Configuration
REQ-027 With COUNT_MON_WRAP_CNT_EN defined, the block SHALL provide wrap_pulse and the wrap_cnt register as specified above.
REQ-028 Without COUNT_MON_WRAP_CNT_EN, wrap_pulse and wrap_cnt SHALL be tied to 0, no wrap logic SHALL be synthesized, and the ports SHALL remain present.

Structure
REQ-029 The shared package count_mon_pkg SHALL hold the FSM state typedef (INIT, LOCKED, SETTLE) and the constants COUNT_W=4 and WRAP_W=8.
REQ-030 The synchronizer chain SHALL be a sub-module count_sync, parameterized by width and SYNC_STAGES.

Verification
REQ-031 Scenario: reset with count_in=4'h3 held, then release at edge 0 -> valid=1 and value=3 by edge 5, and match=0 with threshold=9.
REQ-032 Scenario: step count_in 3->4 -> value=4 after SYNC_STAGES+STABLE_CYCLES+1 edges, with no wrap_pulse.
REQ-033 Scenario: one-cycle glitch 4->7->4 on count_in -> value stays 4, with no match even when threshold=7.
REQ-034 Scenario: step count_in 15->0 -> one wrap_pulse and wrap_cnt=1; after 300 wraps -> wrap_cnt=255.
REQ-035 Scenario: threshold=6 and count_in reaches 6 -> match=1 and stays 1 after count_in moves to 7; clr pulse -> match=0; clr coincident with a re-accept of 6 -> match=1.
REQ-036 Scenario: reset asserted mid-SETTLE -> all outputs 0 immediately; after release the block re-enters INIT and reacquires.
